// File: rtl/freq_meter.sv
// Gated rising-edge counter reporting edges per window in binary and BCD.
// Double-dabble converter runs serially after each window capture.
module freq_meter #(
  parameter logic [31:0] GATE_CYCLES = 32'd50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sig_in,
  output logic [13:0] freq_bin,
  output logic [15:0] freq_bcd,
  output logic        overflow,
  output logic        valid
);

  localparam logic [0:0]  IDLE    = 1'b0;
  localparam logic [0:0]  MEASURE = 1'b1;
  localparam logic [1:0]  CIDLE   = 2'd0;
  localparam logic [1:0]  CSHIFT  = 2'd1;
  localparam logic [1:0]  CDONE   = 2'd2;
  localparam logic [13:0] MAX_CNT = 14'd9999;
  localparam logic [31:0] LAST    = GATE_CYCLES - 32'd1;

  logic        sync1_q, sync2_q, hist_q;
  logic [0:0]  gstate_q, gstate_d;
  logic [31:0] gate_q, gate_d;
  logic [13:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic [13:0] cap_val_q, cap_val_d;
  logic        cap_ovf_q, cap_ovf_d;
  logic [1:0]  cstate_q, cstate_d;
  logic [3:0]  bit_q, bit_d;
  logic [13:0] sh_bin_q, sh_bin_d;
  logic [15:0] sh_bcd_q, sh_bcd_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic        out_ovf_q, out_ovf_d;
  logic        valid_q, valid_d;

  logic        edge_p, measuring, win_end, sat, ovf_next;
  logic [13:0] cnt_next;
  logic [15:0] adj;
  logic [29:0] shifted;

  function automatic logic [15:0] add3(input logic [15:0] v);
    logic [15:0] r;
    logic [3:0]  d;
    r = v;
    for (int i = 0; i < 4; i++) begin
      d = v[i*4 +: 4];
      if (d >= 4'd5) d = d + 4'd3;
      r[i*4 +: 4] = d;
    end
    return r;
  endfunction

  always_comb begin
    edge_p    = sync2_q & ~hist_q;
    measuring = (gstate_q == MEASURE) && enable;
    win_end   = measuring && (gate_q == LAST);
    sat       = edge_p && (cnt_q == MAX_CNT);
    cnt_next  = (edge_p && !sat) ? cnt_q + 14'd1 : cnt_q;
    ovf_next  = ovf_q | sat;
    adj       = add3(sh_bcd_q);
    shifted   = {adj, sh_bin_q} << 1;

    gstate_d  = enable ? MEASURE : IDLE;
    gate_d    = 32'd0;
    cnt_d     = 14'd0;
    ovf_d     = 1'b0;
    cap_val_d = cap_val_q;
    cap_ovf_d = cap_ovf_q;
    if (measuring) begin
      gate_d = win_end ? 32'd0 : gate_q + 32'd1;
      if (win_end) begin
        cap_val_d = cnt_next;
        cap_ovf_d = ovf_next;
      end else begin
        cnt_d = cnt_next;
        ovf_d = ovf_next;
      end
    end

    cstate_d  = cstate_q;
    bit_d     = bit_q;
    sh_bin_d  = sh_bin_q;
    sh_bcd_d  = sh_bcd_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    out_ovf_d = out_ovf_q;
    valid_d   = 1'b0;
    unique case (cstate_q)
      CIDLE: begin
        if (win_end) begin
          cstate_d = CSHIFT;
          bit_d    = 4'd0;
          sh_bin_d = cnt_next;
          sh_bcd_d = 16'h0000;
        end
      end
      CSHIFT: begin
        sh_bcd_d = shifted[29:14];
        sh_bin_d = shifted[13:0];
        bit_d    = bit_q + 4'd1;
        if (bit_q == 4'd13) cstate_d = CDONE;
      end
      CDONE: begin
        bin_d     = cap_val_q;
        bcd_d     = sh_bcd_q;
        out_ovf_d = cap_ovf_q;
        valid_d   = 1'b1;
        cstate_d  = CIDLE;
      end
      default: cstate_d = CIDLE;
    endcase
    // Dropping enable abandons the result in flight; outputs keep old value
    if (!enable) begin
      cstate_d  = CIDLE;
      bin_d     = bin_q;
      bcd_d     = bcd_q;
      out_ovf_d = out_ovf_q;
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      hist_q    <= 1'b0;
      gstate_q  <= IDLE;
      gate_q    <= 32'd0;
      cnt_q     <= 14'd0;
      ovf_q     <= 1'b0;
      cap_val_q <= 14'd0;
      cap_ovf_q <= 1'b0;
      cstate_q  <= CIDLE;
      bit_q     <= 4'd0;
      sh_bin_q  <= 14'd0;
      sh_bcd_q  <= 16'h0000;
      bin_q     <= 14'd0;
      bcd_q     <= 16'h0000;
      out_ovf_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      sync1_q   <= sig_in;
      sync2_q   <= sync1_q;
      hist_q    <= sync2_q;
      gstate_q  <= gstate_d;
      gate_q    <= gate_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      cap_val_q <= cap_val_d;
      cap_ovf_q <= cap_ovf_d;
      cstate_q  <= cstate_d;
      bit_q     <= bit_d;
      sh_bin_q  <= sh_bin_d;
      sh_bcd_q  <= sh_bcd_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      out_ovf_q <= out_ovf_d;
      valid_q   <= valid_d;
    end
  end

  assign freq_bin = bin_q;
  assign freq_bcd = bcd_q;
  assign overflow = out_ovf_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: short-gate instance for the table and
// boundary sequences, long-gate instance for saturation and reset abort.
module tb_freq_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, en1, sig1, val1, ovf1;
  logic [13:0] bin1;
  logic [15:0] bcd1;
  logic        rst2, en2, sig2, val2, ovf2;
  logic [13:0] bin2;
  logic [15:0] bcd2;

  logic gen_on, gen_sig, man_sig;
  int   gen_per, gen_i;
  int   total, bad;

  assign sig1 = gen_on ? gen_sig : man_sig;

  freq_meter #(.GATE_CYCLES(32'd100)) dut (
    .clk(clk), .reset(rst1), .enable(en1), .sig_in(sig1),
    .freq_bin(bin1), .freq_bcd(bcd1), .overflow(ovf1), .valid(val1)
  );

  freq_meter #(.GATE_CYCLES(32'd20000)) dut2 (
    .clk(clk), .reset(rst2), .enable(en2), .sig_in(sig2),
    .freq_bin(bin2), .freq_bcd(bcd2), .overflow(ovf2), .valid(val2)
  );

  typedef struct {
    int          per;
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_valid1(output int n);
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      if (val1 === 1'b1) seen = 1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL valid_timeout actual=none required=pulse");
    end
  endtask

  initial begin
    gen_i = 0;
    forever begin
      @(negedge clk);
      if (gen_per == 0) gen_sig = 1'b0;
      else gen_sig = (gen_i % gen_per) < (gen_per / 2);
      gen_i++;
    end
  end

  initial begin
    int n, nv, cnt;
    int vi[4];
    logic [13:0] vb[4];
    logic [15:0] vd[4];
    logic        vo[4];

    vecs[0] = '{10, 14'd10, 16'h0010, 1'b0};
    vecs[1] = '{4,  14'd25, 16'h0025, 1'b0};
    vecs[2] = '{2,  14'd50, 16'h0050, 1'b0};
    vecs[3] = '{5,  14'd20, 16'h0020, 1'b0};
    vecs[4] = '{20, 14'd5,  16'h0005, 1'b0};
    vecs[5] = '{25, 14'd4,  16'h0004, 1'b0};
    vecs[6] = '{50, 14'd2,  16'h0002, 1'b0};
    vecs[7] = '{0,  14'd0,  16'h0000, 1'b0};

    total = 0; bad = 0;
    rst1 = 1; rst2 = 1; en1 = 0; en2 = 0;
    sig2 = 0; gen_on = 1; gen_per = 0; man_sig = 0;
    repeat (3) @(negedge clk);
    chk("rst_bin", bin1, 0);
    chk("rst_bcd", bcd1, 0);
    chk("rst_ovf", ovf1, 0);
    chk("rst_valid", val1, 0);
    chk("rst2_bin", bin2, 0);
    chk("rst2_valid", val2, 0);
    rst1 = 0; rst2 = 0;
    repeat (2) @(negedge clk);

    en1 = 1;
    wait_valid1(n);
    chk("first_latency", n, 116);
    chk("first_bcd", bcd1, 16'h0000);

    for (int v = 0; v < 8; v++) begin
      gen_per = vecs[v].per;
      wait_valid1(n);
      chk("interval_a", n, 100);
      wait_valid1(n);
      chk("interval_b", n, 100);
      chk($sformatf("bin_p%0d", vecs[v].per), bin1, vecs[v].bin);
      chk($sformatf("bcd_p%0d", vecs[v].per), bcd1, vecs[v].bcd);
      chk($sformatf("ovf_p%0d", vecs[v].per), ovf1, vecs[v].ovf);
    end

    @(negedge clk);
    chk("valid_width", val1, 0);
    repeat (33) @(negedge clk);
    en1 = 0;
    cnt = 0;
    repeat (250) begin
      @(negedge clk);
      if (val1 === 1'b1) cnt++;
    end
    chk("no_valid_disabled", cnt, 0);
    chk("hold_bcd_disabled", bcd1, 16'h0000);
    en1 = 1;
    wait_valid1(n);
    chk("reenable_latency", n, 116);

    // Edge in last cycle of window 1, next in cycle 0 of window 3
    en1 = 0; gen_on = 0; man_sig = 0;
    repeat (5) @(negedge clk);
    en1 = 1;
    nv = 0;
    for (int idx = 1; idx <= 330; idx++) begin
      @(negedge clk);
      if (val1 === 1'b1 && nv < 4) begin
        vi[nv] = idx; vb[nv] = bin1; nv++;
      end
      man_sig = (idx == 98) || (idx == 199);
    end
    chk("bnd_count", nv, 3);
    if (nv == 3) begin
      chk("bnd_t0", vi[0], 116);
      chk("bnd_v0", vb[0], 1);
      chk("bnd_t1", vi[1], 216);
      chk("bnd_v1", vb[1], 0);
      chk("bnd_t2", vi[2], 316);
      chk("bnd_v2", vb[2], 1);
    end

    nv = 0;
    for (int idx = 0; idx <= 40030; idx++) begin
      @(negedge clk);
      if (val2 === 1'b1 && nv < 4) begin
        vi[nv] = idx; vb[nv] = bin2; vd[nv] = bcd2; vo[nv] = ovf2; nv++;
      end
      if (idx == 0) en2 = 1;
      if (idx < 20000) sig2 = (idx % 2) == 0;
      else if (idx < 40000) sig2 = ((idx - 20000) % 4) < 2;
      else sig2 = 0;
    end
    chk("sat_count", nv, 2);
    if (nv == 2) begin
      chk("sat_t0", vi[0], 20016);
      chk("sat_bin", vb[0], 9999);
      chk("sat_bcd", vd[0], 16'h9999);
      chk("sat_ovf", vo[0], 1);
      chk("half_t1", vi[1], 40016);
      chk("half_bin", vb[1], 5000);
      chk("half_bcd", vd[1], 16'h5000);
      chk("half_ovf", vo[1], 0);
    end
    @(negedge clk);
    en2 = 0; sig2 = 0;
    repeat (5) @(negedge clk);

    // 1234 edges, then reset lands while that capture is being converted
    cnt = 0;
    for (int idx = 0; idx <= 20006; idx++) begin
      @(negedge clk);
      if (val2 === 1'b1) cnt++;
      if (idx == 0) en2 = 1;
      sig2 = (idx >= 1) && (idx <= 4933) && (((idx - 1) % 4) == 0);
      if (idx == 20005) rst2 = 1;
      if (idx == 20006) begin
        chk("rst_mid_bin", bin2, 0);
        chk("rst_mid_bcd", bcd2, 0);
        chk("rst_mid_ovf", ovf2, 0);
        chk("rst_mid_valid", val2, 0);
        rst2 = 0;
        en2 = 0;
      end
    end
    repeat (200) begin
      @(negedge clk);
      if (val2 === 1'b1) cnt++;
    end
    chk("rst_no_valid", cnt, 0);

    nv = 0;
    for (int idx = 0; idx <= 20030; idx++) begin
      @(negedge clk);
      if (val2 === 1'b1 && nv < 4) begin
        vi[nv] = idx; vb[nv] = bin2; vd[nv] = bcd2; vo[nv] = ovf2; nv++;
      end
      if (idx == 0) en2 = 1;
      sig2 = (idx >= 1) && (idx <= 25) && (((idx - 1) % 4) == 0);
    end
    chk("post_rst_count", nv, 1);
    if (nv >= 1) begin
      chk("post_rst_t", vi[0], 20016);
      chk("post_rst_bin", vb[0], 7);
      chk("post_rst_bcd", vd[0], 16'h0007);
      chk("post_rst_ovf", vo[0], 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 50000000, clk cycles per measurement window (1 s at 50 MHz); legal range 16..2^32-1.
REQ-002 clk  input  1  single system clock, all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  measurement run control, synchronous to clk.
REQ-005 sig_in  input  1  signal under measurement, asynchronous to clk.
REQ-006 freq_bin  output  14  last measured rising-edge count, binary, saturated at 9999.
REQ-007 freq_bcd  output  16  last measured count as 4 BCD digits, [15:12] thousands .. [3:0] units.
REQ-008 overflow  output  1  last window had more than 9999 edges.
REQ-009 valid  output  1  one-cycle pulse; freq_bin/freq_bcd/overflow updated this cycle.

Function
REQ-010 sig_in SHALL pass a 2-flop synchronizer plus one history flop; edge pulse = sync2 & ~hist, one clk cycle per sig_in rising edge.
REQ-011 Gate FSM SHALL have states IDLE and MEASURE; IDLE -> MEASURE on cycle after enable sampled high; MEASURE -> IDLE on cycle after enable sampled low.
REQ-012 In MEASURE, gate counter SHALL run 0..GATE_CYCLES-1 and wrap to 0; windows SHALL be back-to-back with no dead cycles.
REQ-013 Edge counter SHALL increment on each edge pulse and saturate at 9999; a 10000th edge SHALL set an internal overflow flag for the window.
REQ-014 Edge pulse in the last window cycle (gate counter = GATE_CYCLES-1) SHALL count in the ending window; edge pulse in cycle 0 SHALL count in the new window.
REQ-015 At window end, captured value = min(edge count incl. last-cycle edge, 9999) and overflow flag SHALL load a shadow register; edge counter and flag SHALL clear to 0 for the next window in the same cycle.
REQ-016 Converter FSM SHALL have states CIDLE, CSHIFT, CDONE; CIDLE -> CSHIFT on capture; CSHIFT runs exactly 14 cycles of shift-and-add-3 (add 3 to any BCD digit >= 5 before each shift); CSHIFT -> CDONE -> CIDLE.
REQ-017 In CDONE, freq_bin, freq_bcd, overflow SHALL update and valid SHALL be 1 for exactly that cycle; latency from window-end cycle to valid = 16 clk cycles.
REQ-018 Conversion (16 cycles) SHALL complete before next capture since GATE_CYCLES >= 16; a capture arriving outside CIDLE is not possible for legal parameters.
REQ-019 enable low SHALL clear gate counter, edge counter, overflow flag and abort any conversion (converter to CIDLE, no valid); outputs SHALL hold last result.
REQ-020 enable re-asserted SHALL start a fresh full window from gate counter 0; a partial window SHALL never be reported.
REQ-021 sig_in edges closer than 2 clk cycles are not guaranteed counted; max countable rate is clk/2.

Reset
REQ-022 reset SHALL force gate FSM IDLE, converter CIDLE, all counters/shadow registers 0, freq_bin=0, freq_bcd=16'h0000, overflow=0, valid=0.
REQ-023 reset SHALL take priority over enable and all other events in the same cycle, including mid-window and mid-conversion; no valid SHALL follow a reset until a full new window completes.

Verification
REQ-024 GATE_CYCLES=100, enable=1, sig_in period 10 clk -> valid every 100 cycles, freq_bin=10, freq_bcd=16'h0010, overflow=0.
REQ-025 GATE_CYCLES=20000, sig_in toggling every clk -> freq_bin=9999, freq_bcd=16'h9999, overflow=1; next window with sig_in period 4 clk (5000 edges) -> freq_bcd=16'h5000, overflow=0.
REQ-026 GATE_CYCLES=100, single edge pulse placed in cycle 99 then one in cycle 0 of next window -> consecutive results freq_bin=1 and freq_bin=1 (not 2 and 0).
REQ-027 GATE_CYCLES=100, sig_in held 0 -> valid each window, freq_bcd=16'h0000; enable dropped at window cycle 50 -> no valid; re-enabled -> first valid 116 cycles after MEASURE entry.
REQ-028 reset asserted during CSHIFT with capture value 1234 -> no valid, all outputs 0 next cycle; after reset release and enable, first result reflects only post-reset edges.
